// File: rtl/seq_pkg.sv
// Shared types and constants for the serial pattern transmitter.
package seq_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} seq_tx_state_t;

    localparam logic [2:0] SEQ_PAT_101 = 3'b101;

endpackage

// File: rtl/seq_bit_serializer.sv
// Parallel-load shift register; the MSB is the serial output.
// Zeros shift in from the bottom, so once the last bit has left, the
// output idles at 0 without any extra clearing.
module seq_bit_serializer #(
    parameter int W = 3
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic         i_shift,
    input  logic [W-1:0] i_data,
    output logic         o_msb
);

    logic [W-1:0] r_sr;

    // Load takes priority over shift so a back-to-back repetition reloads on its LSB cycle
    always_ff @(posedge i_clk) begin
        if (i_rst)        r_sr <= '0;
        else if (i_load)  r_sr <= i_data;
        else if (i_shift) r_sr <= {r_sr[W-2:0], 1'b0};
    end

    assign o_msb = r_sr[W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial bit-pattern transmitter: shifts a latched pattern MSB-first,
// repeated with idle-zero gaps between repetitions.
// Optional macro SEQ_PATTERN_TX_ERR_INJ_EN adds i_err_inj, which inverts the
// LSB of every emitted repetition when sampled high with start.
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int               PAT_W       = 3,
    parameter logic [PAT_W-1:0] PAT_DEFAULT = PAT_W'(SEQ_PAT_101),
    parameter int               REP_W       = 8,
    parameter int               GAP_W       = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
`ifdef SEQ_PATTERN_TX_ERR_INJ_EN
    input  logic             i_err_inj,
`endif
    input  logic             i_pat_sel_dflt,
    input  logic [PAT_W-1:0] i_pat,
    input  logic [REP_W-1:0] i_repeat_cnt,
    input  logic [GAP_W-1:0] i_gap,
    output logic             o_x,
    output logic             o_bit_valid,
    output logic             o_busy,
    output logic             o_done
);

    localparam int               IDX_W   = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_W - 1);

    seq_tx_state_t    r_state;
    logic [IDX_W-1:0] r_bit_idx;
    logic [REP_W-1:0] r_reps_left;
    logic [GAP_W-1:0] r_gap_len;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [PAT_W-1:0] r_pat;

    logic             w_err;
    logic [PAT_W-1:0] w_pat_in;
    logic [PAT_W-1:0] w_ld_data;
    logic             w_start_ok;
    logic             w_last_bit;
    logic             w_more_reps;
    logic             w_has_gap;
    logic             w_gap_end;
    logic             w_rep_b2b;
    logic             w_load;
    logic             w_shift;

`ifdef SEQ_PATTERN_TX_ERR_INJ_EN
    assign w_err = i_err_inj;
`else
    assign w_err = 1'b0;
`endif

    // The stored pattern already carries the injected error, so every repetition reloads it as-is
    assign w_pat_in    = (i_pat_sel_dflt ? PAT_DEFAULT : i_pat) ^ {{(PAT_W-1){1'b0}}, w_err};
    assign w_start_ok  = (r_state == IDLE) && i_start;
    assign w_last_bit  = (r_bit_idx == '0);
    assign w_more_reps = (r_reps_left > REP_W'(1));
    assign w_has_gap   = (r_gap_len != '0);
    assign w_gap_end   = (r_state == GAP) && (r_gap_cnt == GAP_W'(1));
    assign w_rep_b2b   = (r_state == SHIFT) && w_last_bit && w_more_reps && !w_has_gap;
    assign w_load      = w_start_ok || w_rep_b2b || w_gap_end;
    assign w_shift     = (r_state == SHIFT);
    assign w_ld_data   = w_start_ok ? w_pat_in : r_pat;

    seq_bit_serializer #(.W(PAT_W)) u_ser (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_data  (w_ld_data),
        .o_msb   (o_x)
    );

    // Frame sequencing: bit/rep/gap counters and registered status outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_bit_idx   <= '0;
            r_reps_left <= '0;
            r_gap_len   <= '0;
            r_gap_cnt   <= '0;
            r_pat       <= '0;
            o_bit_valid <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_pat       <= w_pat_in;
                        r_reps_left <= (i_repeat_cnt == '0) ? REP_W'(1) : i_repeat_cnt;
                        r_gap_len   <= i_gap;
                        r_bit_idx   <= IDX_MSB;
                        o_bit_valid <= 1'b1;
                        o_busy      <= 1'b1;
                        r_state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!w_last_bit) begin
                        r_bit_idx <= r_bit_idx - IDX_W'(1);
                    end else if (w_more_reps) begin
                        r_reps_left <= r_reps_left - REP_W'(1);
                        if (w_has_gap) begin
                            r_gap_cnt <= r_gap_len;
                            r_state   <= GAP;
                        end else begin
                            r_bit_idx <= IDX_MSB;
                        end
                    end else begin
                        o_bit_valid <= 1'b0;
                        o_busy      <= 1'b0;
                        o_done      <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                GAP: begin
                    r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                    if (w_gap_end) begin
                        r_bit_idx <= IDX_MSB;
                        r_state   <= SHIFT;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: stimulus pushes expected serial
// tokens, a negedge monitor pops and compares on every valid bit or done.
// A non-overlapping 101 detector model watches x for loopback hit counts.
module tb_seq_pattern_tx;

    typedef struct packed {
        logic is_done;
        logic x;
    } tok_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       pat_sel_dflt;
    logic [2:0] pat;
    logic [7:0] repeat_cnt;
    logic [3:0] gap;
    logic       x, bit_valid, busy, done;
`ifdef SEQ_PATTERN_TX_ERR_INJ_EN
    logic       err_inj;
`endif

    tok_t q[$];
    tok_t t;
    int   n_pass  = 0;
    int   n_total = 0;
    int   busy_cyc = 0;
    int   hits = 0;
    int   det_st = 0;
    logic prev_busy = 1'b0;

    always #5 clk = ~clk;

    seq_pattern_tx dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
`ifdef SEQ_PATTERN_TX_ERR_INJ_EN
        .i_err_inj      (err_inj),
`endif
        .i_pat_sel_dflt (pat_sel_dflt),
        .i_pat          (pat),
        .i_repeat_cnt   (repeat_cnt),
        .i_gap          (gap),
        .o_x            (x),
        .o_bit_valid    (bit_valid),
        .o_busy         (busy),
        .o_done         (done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push n expected bits (MSB first from bits[n-1]) and optionally a done token
    task automatic push_bits(input logic [31:0] bits, input int n, input bit with_done);
        for (int i = n - 1; i >= 0; i--) q.push_back('{is_done: 1'b0, x: bits[i]});
        if (with_done) q.push_back('{is_done: 1'b1, x: 1'b0});
    endtask

    task automatic issue_start(input logic sel, input logic [2:0] p,
                               input logic [7:0] rep, input logic [3:0] g);
        busy_cyc     = 0;
        hits         = 0;
        det_st       = 0;
        pat_sel_dflt = sel;
        pat          = p;
        repeat_cnt   = rep;
        gap          = g;
        start        = 1'b1;
        tick();
        start = 1'b0;
        chk("first_bit_latency", {31'd0, bit_valid}, 32'd1);
    endtask

    task automatic wait_idle(input int exp_busy, input int exp_hits);
        int k;
        k = 0;
        while (q.size() != 0 && k < 300) begin
            tick();
            k++;
        end
        chk("frame_drained", q.size(), 32'd0);
        tick();
        tick();
        chk("busy_cycles", busy_cyc, exp_busy);
        chk("detector_hits", hits, exp_hits);
        chk("idle_after_frame", {29'd0, busy, bit_valid, done}, 32'd0);
    endtask

    // Monitor: detector model plus scoreboard pop on each valid bit / done pulse
    initial begin
        forever begin
            @(negedge clk);
            case (det_st)
                0: det_st = x ? 1 : 0;
                1: det_st = x ? 1 : 2;
                default: begin
                    if (x) hits++;
                    det_st = 0;
                end
            endcase
            if (busy) busy_cyc++;
            if (bit_valid || done) begin
                if (q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_output: x=%0d bit_valid=%0d done=%0d, expected no output",
                             x, bit_valid, done);
                end else begin
                    t = q.pop_front();
                    chk("token_kind_done", {31'd0, done}, {31'd0, t.is_done});
                    if (!t.is_done) begin
                        chk("serial_x", {31'd0, x}, {31'd0, t.x});
                        chk("busy_with_bit", {31'd0, busy}, 32'd1);
                    end else begin
                        chk("done_quiet_outputs", {30'd0, busy, bit_valid}, 32'd0);
                        chk("done_after_last_bit", {31'd0, prev_busy}, 32'd1);
                    end
                end
            end
            prev_busy = busy;
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; pat_sel_dflt = 1'b1; pat = 3'b000;
        repeat_cnt = 8'd0; gap = 4'd0;
`ifdef SEQ_PATTERN_TX_ERR_INJ_EN
        err_inj = 1'b0;
`endif
        tick();
        tick();
        chk("reset_outputs", {28'd0, x, bit_valid, busy, done}, 32'd0);
        rst = 1'b0;
        tick();

        // 1: default pattern, single repetition
        push_bits(32'b101, 3, 1'b1);
        issue_start(1'b1, 3'b000, 8'd1, 4'd0);
        wait_idle(3, 1);

        // 2: two repetitions separated by two idle zeros
        push_bits(32'b10100101, 8, 1'b1);
        issue_start(1'b1, 3'b000, 8'd2, 4'd2);
        wait_idle(8, 2);

        // 3: zero repeat count behaves as one, no trailing gap
        push_bits(32'b101, 3, 1'b1);
        issue_start(1'b1, 3'b000, 8'd0, 4'd5);
        wait_idle(3, 1);

        // 4: user pattern 110, start re-pulsed mid-frame with a different pattern
        push_bits(32'b110, 3, 1'b1);
        issue_start(1'b0, 3'b110, 8'd1, 4'd0);
        tick();
        start = 1'b1;
        pat   = 3'b011;
        tick();
        start = 1'b0;
        wait_idle(3, 0);

        // Back-to-back repetitions of user pattern 011
        push_bits(32'b011011, 6, 1'b1);
        issue_start(1'b0, 3'b011, 8'd2, 4'd0);
        wait_idle(6, 1);

        // 5: reset mid-frame, then a clean restart
        push_bits(32'b10, 2, 1'b0);
        issue_start(1'b1, 3'b000, 8'd3, 4'd0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midframe_reset_outputs", {28'd0, x, bit_valid, busy, done}, 32'd0);
        chk("midframe_reset_drained", q.size(), 32'd0);
        push_bits(32'b101101101, 9, 1'b1);
        issue_start(1'b1, 3'b000, 8'd3, 4'd0);
        wait_idle(9, 3);

`ifdef SEQ_PATTERN_TX_ERR_INJ_EN
        // 6: LSB of each repetition inverted
        err_inj = 1'b1;
        push_bits(32'b1000100, 7, 1'b1);
        issue_start(1'b1, 3'b000, 8'd2, 4'd1);
        err_inj = 1'b0;
        wait_idle(7, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
